addsub_seq: RTL and testbench
=============================

# addsub_seq

Multi-cycle wide adder/subtractor controller that sequences a single 4-bit add/subtract slice across NIB nibbles, LSB first, propagating carry between passes. It gives the datapath a WIDTH-bit signed/unsigned add or subtract without instantiating a full-width adder. A requester drives it with a start/busy/done handshake. Result flags match the 4-bit slice convention: S sum, C carry/no-borrow, V signed overflow.

## Interface
- NIB, default 4: number of 4-bit nibbles; operand width WIDTH = 4*NIB, legal range 2..8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- se  input  1  0 = A+B, 1 = A-B (two's complement: B inverted, carry-in 1); captured with start.
- A  input  WIDTH  operand A; captured with start.
- B  input  WIDTH  operand B; captured with start.
- busy  output  1  high while nibble passes are in progress.
- done  output  1  one-cycle pulse: S/C/V were just committed.
- S  output  WIDTH  committed result.
- C  output  1  carry out of the MSB (subtract: 1 = no borrow, A>=B unsigned).
- V  output  1  signed overflow of the committed result.
- abort  input  1  present only with ADDSUB_SEQ_ABORT_EN.

## Operation
- States: IDLE, RUN. Nibble index idx is clog2(NIB) bits wide. Internal registers: working sum, running carry, committed S/C/V.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, S=0, C=0, V=0, idx=0, working registers cleared.
- IDLE with start=1:
  - capture A, B and se.
  - set carry=se and idx=0.
  - go to RUN.
- RUN, each cycle:
  - compute nib = A[idx] + (B[idx] ^ {4{se}}) + carry, 5-bit result.
  - write nib[3:0] to working nibble idx; carry <= nib[4].
  - idx increments.
- Last nibble (idx=NIB-1):
  - S <= working value with the final nibble inserted; C <= nib[4].
  - V <= carry into bit 3 XOR carry out of bit 3, taken from the final nibble.
  - done <= 1; go to IDLE.
- start while busy=1 is ignored; it is not queued.
- start in the cycle done=1 is accepted (back-to-back; busy=0 in that cycle).
- S/C/V change only at commit or reset and hold between operations. Captured operands isolate the operation from A/B/se changes after start.

## Timing
- start sampled at edge 0 gives busy=1 after edges 1..NIB; nibble i is processed at edge i+1.
- Commit and done occur at edge NIB; busy falls at the same edge. Latency is NIB cycles from the start edge to done and valid S/C/V.
- Throughput: one operation per NIB cycles with back-to-back start.
- done stays high exactly one cycle unless a new commit follows, which cannot happen for NIB≥2.
- Reset asserted mid-RUN: immediate return to reset values; no done; the partial result is discarded.

## Configuration
- ADDSUB_SEQ_ABORT_EN defined:
  - adds the abort input.
  - abort=1 in RUN: next edge goes to IDLE, busy=0, no done, S/C/V keep the previous committed values.
  - abort in IDLE has no effect; abort and start together in IDLE start the operation.
- Not defined: no abort port; every accepted operation runs to completion.

## Test plan
- NIB=4, se=0, A=0xFFFF, B=0x0001, start one cycle -> busy for 4 cycles, done at edge 4, S=0x0000, C=1, V=0.
- se=1, A=0x0000, B=0x0001 -> S=0xFFFF, C=0 (borrow), V=0. Then se=1, A=0x0005, B=0x0003 -> S=0x0002, C=1, V=0.
- Overflow: se=1, A=0x8000, B=0x0001 -> S=0x7FFF, C=1, V=1. se=0, A=0x7FFF, B=0x0001 -> S=0x8000, C=0, V=1.
- start pulsed at cycle 2 of an operation (se=0, 0x1234+0x1111) with different operands -> ignored, S=0x2345. Back-to-back start in the done cycle -> second done exactly 4 cycles later.
- rst_n low at cycle 2 of RUN -> busy, done, S, C, V all 0 immediately; no done after release.
- ADDSUB_SEQ_ABORT_EN: commit 0x0002, then start 0x1000+0x0001 and abort at cycle 2 -> busy=0 next cycle, no done, S remains 0x0002.

Source files
------------

// File: rtl/addsub_seq.sv
// Wide add/subtract built from one 4-bit slice stepped across NIB nibbles LSB first; optional abort via ADDSUB_SEQ_ABORT_EN.
// Latency NIB cycles from accepted start to done; S/C/V held between commits.
// Backpressure: start is ignored while busy, and a start in the done cycle is accepted.
module addsub_seq #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ADDSUB_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic             se,
    input  logic [4*NIB-1:0] A,
    input  logic [4*NIB-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] S,
    output logic             C,
    output logic             V
);
    localparam int WIDTH = 4 * NIB;
    localparam int IDXW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, work_q, work_d, s_q, s_d;
    logic              se_q, se_d, carry_q, carry_d;
    logic              c_q, c_d, v_q, v_d, done_q, done_d;

    logic [3:0]        a_nib, b_nib;
    logic [4:0]        nib_sum;
    logic [3:0]        low_sum;

    // One slice pass: B is inverted for subtract, the +1 arrives as the initial carry.
    always_comb begin
        a_nib   = a_q[4*idx_q +: 4];
        b_nib   = b_q[4*idx_q +: 4] ^ {4{se_q}};
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
        low_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry_q};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        se_d    = se_q;
        carry_d = carry_q;
        work_d  = work_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    se_d    = se;
                    carry_d = se;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[4*idx_q +: 4] = nib_sum[3:0];
                carry_d              = nib_sum[4];
                idx_d                = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NIB - 1)) begin
                    s_d     = work_d;
                    c_d     = nib_sum[4];
                    v_d     = low_sum[3] ^ nib_sum[4];
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
`ifdef ADDSUB_SEQ_ABORT_EN
                // Abort discards the partial result and leaves the last commit visible.
                if (abort) begin
                    s_d     = s_q;
                    c_d     = c_q;
                    v_d     = v_q;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            se_q    <= 1'b0;
            carry_q <= 1'b0;
            work_q  <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            se_q    <= se_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign S    = s_q;
    assign C    = c_q;
    assign V    = v_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq (NIB=4): full-width reference model feeds a scoreboard queue.
// Checks latency, ignored/back-to-back start, async reset mid-run and, when enabled, abort.
module tb_addsub_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, se;
    logic [W-1:0] A, B;
    logic         busy, done, C, V;
    logic [W-1:0] S;
`ifdef ADDSUB_SEQ_ABORT_EN
    logic         abort;
`endif

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    addsub_seq #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef ADDSUB_SEQ_ABORT_EN
        .abort (abort),
`endif
        .start (start),
        .se    (se),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C     (C),
        .V     (V)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic s_e, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        res_t       r;
        full = s_e ? ({1'b0, a} + {1'b0, ~b} + 1) : ({1'b0, a} + {1'b0, b});
        r.s  = full[W-1:0];
        r.c  = full[W];
        if (s_e) r.v = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
        else     r.v = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
        return r;
    endfunction

    // Drives a request at the current (negedge) time; expected result queued when push is set.
    task automatic issue(input logic s_e, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        start = 1'b1;
        se    = s_e;
        A     = a;
        B     = b;
        if (push) exp_q.push_back(model(s_e, a, b));
    endtask

    // Waits for done, scrambling inputs after start; ign injects a start at cycle 2 that must be dropped.
    task automatic wait_done(input string tag, input bit ign);
        int   cyc;
        res_t e;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                A     = 16'hDEAD;
                B     = 16'hBEEF;
                se    = ~se;
            end
            if (ign && cyc == 2) begin
                start = 1'b1;
                se    = 1'b1;
                A     = 16'hAAAA;
                B     = 16'h5555;
            end
            if (ign && cyc == 3) start = 1'b0;
            if (done) break;
            check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_timeout: observed no done expected done", tag);
        end else begin
            check({tag, "_lat"}, 32'(cyc - 1), 32'(NIB));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL %s_sb: observed done expected none", tag);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_S"}, 32'(S), 32'(e.s));
                check({tag, "_C"}, 32'(C), 32'(e.c));
                check({tag, "_V"}, 32'(V), 32'(e.v));
            end
        end
    endtask

    task automatic run(input string tag, input logic s_e, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        issue(s_e, a, b, 1'b1);
        wait_done(tag, 1'b0);
    endtask

    initial begin
        logic [W-1:0] held_s;
        rst_n = 1'b0;
        start = 1'b0;
        se    = 1'b0;
        A     = '0;
        B     = '0;
`ifdef ADDSUB_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_S",    32'(S),    32'd0);
        check("rst_C",    32'(C),    32'd0);
        check("rst_V",    32'(V),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("wrap_add",  1'b0, 16'hFFFF, 16'h0001);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("S_hold", 32'(S), 32'h0000);
        run("borrow",    1'b1, 16'h0000, 16'h0001);
        run("sub_small", 1'b1, 16'h0005, 16'h0003);
        run("ovf_sub",   1'b1, 16'h8000, 16'h0001);
        run("ovf_add",   1'b0, 16'h7FFF, 16'h0001);
        run("mix_add",   1'b0, 16'h89AB, 16'h7654);
        run("mix_sub",   1'b1, 16'h1234, 16'h4321);
        for (int i = 0; i < 4; i++) run("rand", 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

        @(negedge clk);
        issue(1'b0, 16'h1234, 16'h1111, 1'b1);
        wait_done("ignore", 1'b1);
        check("ignore_S", 32'(S), 32'h2345);
        repeat (6) begin
            @(negedge clk);
            check("ignore_no_queue", 32'({busy, done}), 32'd0);
        end

        @(negedge clk);
        issue(1'b0, 16'h0F0F, 16'h00F1, 1'b1);
        wait_done("b2b_first", 1'b0);
        issue(1'b1, 16'h4000, 16'h4001, 1'b1);
        wait_done("b2b_second", 1'b0);

        @(negedge clk);
        issue(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_S",    32'(S),    32'd0);
        check("mid_rst_CV",   32'({C, V}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(done), 32'd0);
        end

`ifdef ADDSUB_SEQ_ABORT_EN
        run("pre_abort", 1'b1, 16'h0005, 16'h0003);
        held_s = S;
        @(negedge clk);
        issue(1'b0, 16'h1000, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_S", 32'(S), 32'h0002);
        repeat (5) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_S_hold", 32'(S), 32'(held_s));
        @(negedge clk);
        abort = 1'b1;
        issue(1'b0, 16'h0100, 16'h0023, 1'b1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_start", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("abort_idle", 1'b0);
`else
        held_s = S;
        check("final_S_hold", 32'(held_s), 32'h0000);
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
